// File: rtl/alu_arbiter_pkg.sv
// rtl/alu_arbiter_pkg.sv - shared ALU opcodes, boolean constants and arbitration modes
package alu_arbiter_pkg;

    // ALU operation codes carried on req*_alucode
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLT  = 5'd2;
    localparam logic [4:0] ALU_SLTU = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;
    localparam logic [4:0] ALU_AND  = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // PRIO_MODE values
    localparam int ARB_RR    = 0;
    localparam int ARB_FIXED = 1;

endpackage

// File: rtl/alu_arbiter_alu.sv
// rtl/alu_arbiter_alu.sv - combinational 32-bit integer ALU shared by the arbiter
// Ports:
//   alucode        operation select (ALU_* codes)
//   r1, r2         register operands
//   pc, imm        alternate operand sources
//   using_r2       1: second operand is r2, 0: imm
//   using_pc       1: first operand is pc, 0: r1
//   result         operation result (0 for undefined opcodes)
module alu
    import alu_arbiter_pkg::*;
(
    input  logic [4:0]  alucode,
    input  logic [31:0] r1,
    input  logic [31:0] r2,
    input  logic [31:0] pc,
    input  logic [31:0] imm,
    input  logic        using_r2,
    input  logic        using_pc,
    output logic [31:0] result
);

    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [4:0]  shamt;

    always_comb begin
        op_a   = using_pc ? pc : r1;
        op_b   = using_r2 ? r2 : imm;
        shamt  = op_b[4:0];
        result = '0;
        case (alucode)
            ALU_ADD:  result = op_a + op_b;
            ALU_SUB:  result = op_a - op_b;
            ALU_SLT:  result = {31'd0, $signed(op_a) < $signed(op_b)};
            ALU_SLTU: result = {31'd0, op_a < op_b};
            ALU_XOR:  result = op_a ^ op_b;
            ALU_OR:   result = op_a | op_b;
            ALU_AND:  result = op_a & op_b;
            ALU_SLL:  result = op_a << shamt;
            ALU_SRL:  result = op_a >> shamt;
            ALU_SRA:  result = $unsigned($signed(op_a) >>> shamt);
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-port valid/ready arbiter sharing one ALU with a registered result
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqK_valid/ready            request handshake for port K (K = 0, 1)
//   reqK_alucode/op1/op2        operation and operands for port K
//   rspK_valid/ready            response handshake for port K
//   rsp_result                  shared registered result, owned by the port whose rsp valid is high
//   busy                        result register occupied
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = ARB_RR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [4:0]  req0_alucode,
    input  logic [31:0] req0_op1,
    input  logic [31:0] req0_op2,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [4:0]  req1_alucode,
    input  logic [31:0] req1_op1,
    input  logic [31:0] req1_op2,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_result,
    output logic        busy
);

    logic        out_valid_q,  out_valid_d;
    logic        out_owner_q,  out_owner_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] result_q,     result_d;

    logic        drain;
    logic        free;
    logic        any_req;
    logic        grant_sel;
    logic        accept;
    logic [4:0]  alu_code;
    logic [31:0] alu_r1;
    logic [31:0] alu_r2;
    logic [31:0] alu_out;

    always_comb begin
        drain   = out_valid_q & (out_owner_q ? rsp1_ready : rsp0_ready);
        // A draining slot counts as free so back-to-back operations need no bubble
        free    = ~out_valid_q | drain;
        any_req = req0_valid | req1_valid;

        if (req0_valid && req1_valid) begin
            grant_sel = (PRIO_MODE == ARB_FIXED) ? 1'b0 : ~last_grant_q;
        end else begin
            grant_sel = req1_valid;
        end

        accept     = free & any_req;
        req0_ready = accept & ~grant_sel;
        req1_ready = accept & grant_sel;

        alu_code = grant_sel ? req1_alucode : req0_alucode;
        alu_r1   = grant_sel ? req1_op1     : req0_op1;
        alu_r2   = grant_sel ? req1_op2     : req0_op2;

        out_valid_d  = out_valid_q;
        out_owner_d  = out_owner_q;
        last_grant_d = last_grant_q;
        result_d     = result_q;
        if (accept) begin
            out_valid_d  = 1'b1;
            out_owner_d  = grant_sel;
            last_grant_d = grant_sel;
            result_d     = alu_out;
        end else if (drain) begin
            // Result value is left in place; only ownership of the slot is released
            out_valid_d = 1'b0;
        end
    end

    alu u_alu (
        .alucode  (alu_code),
        .r1       (alu_r1),
        .r2       (alu_r2),
        .pc       (32'd0),
        .imm      (32'd0),
        .using_r2 (TRUE),
        .using_pc (FALSE),
        .result   (alu_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q  <= 1'b0;
            out_owner_q  <= 1'b0;
            // Starting at 1 makes port 0 win the first tie
            last_grant_q <= 1'b1;
            result_q     <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_owner_q  <= out_owner_d;
            last_grant_q <= last_grant_d;
            result_q     <= result_d;
        end
    end

    assign rsp0_valid = out_valid_q & ~out_owner_q;
    assign rsp1_valid = out_valid_q &  out_owner_q;
    assign rsp_result = result_q;
    assign busy       = out_valid_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter in round-robin and fixed-priority modes
module tb_alu_arbiter;
    import alu_arbiter_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic [4:0]  req0_alucode, req1_alucode;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic        rsp0_ready, rsp1_ready;

    logic        rdy0_rr, rdy1_rr, v0_rr, v1_rr, busy_rr;
    logic [31:0] res_rr;
    logic        rdy0_fx, rdy1_fx, v0_fx, v1_fx, busy_fx;
    logic [31:0] res_fx;

    int n_cmp = 0;
    int n_bad = 0;

    alu_arbiter #(.PRIO_MODE(ARB_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0_rr), .req0_alucode(req0_alucode),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(rdy1_rr), .req1_alucode(req1_alucode),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(v0_rr), .rsp0_ready(rsp0_ready),
        .rsp1_valid(v1_rr), .rsp1_ready(rsp1_ready),
        .rsp_result(res_rr), .busy(busy_rr)
    );

    alu_arbiter #(.PRIO_MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(rdy0_fx), .req0_alucode(req0_alucode),
        .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req1_valid(req1_valid), .req1_ready(rdy1_fx), .req1_alucode(req1_alucode),
        .req1_op1(req1_op1), .req1_op2(req1_op2),
        .rsp0_valid(v0_fx), .rsp0_ready(rsp0_ready),
        .rsp1_valid(v1_fx), .rsp1_ready(rsp1_ready),
        .rsp_result(res_fx), .busy(busy_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [4:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [4:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic r0, input logic r1);
        req0_valid = v0; req0_alucode = c0; req0_op1 = a0; req0_op2 = b0;
        req1_valid = v1; req1_alucode = c1; req1_op1 = a1; req1_op2 = b1;
        rsp0_ready = r0; rsp1_ready = r1;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Reference ALU, written from the opcode definitions
    function automatic logic [31:0] ref_alu(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b % 32);
        case (c)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a + (~b) + 32'd1;
            ALU_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            ALU_SLTU: return (longint'({32'd0, a}) < longint'({32'd0, b})) ? 32'd1 : 32'd0;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SLL:  return a << sh;
            ALU_SRL:  return a >> sh;
            ALU_SRA:  return 32'(int'(a) >>> sh);
            default:  return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic        v0; logic [4:0] c0; logic [31:0] a0; logic [31:0] b0;
        logic        v1; logic [4:0] c1; logic [31:0] a1; logic [31:0] b1;
        logic        r0; logic r1;
        logic        e_rdy0; logic e_rdy1;
        logic        e_v0;   logic e_v1;
        logic [31:0] e_res;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic [4:0] c0, input logic [31:0] a0, input logic [31:0] b0,
                                input logic v1, input logic [4:0] c1, input logic [31:0] a1, input logic [31:0] b1,
                                input logic r0, input logic r1, input logic e_rdy0, input logic e_rdy1,
                                input logic e_v0, input logic e_v1, input logic [31:0] e_res);
        vec_t t;
        t.v0 = v0; t.c0 = c0; t.a0 = a0; t.b0 = b0;
        t.v1 = v1; t.c1 = c1; t.a1 = a1; t.b1 = b1;
        t.r0 = r0; t.r1 = r1;
        t.e_rdy0 = e_rdy0; t.e_rdy1 = e_rdy1; t.e_v0 = e_v0; t.e_v1 = e_v1; t.e_res = e_res;
        return t;
    endfunction

    vec_t vecs[12];

    // Random-phase reference state: index 0 = round-robin, 1 = fixed priority
    logic        m_v[2];
    logic        m_o[2];
    logic        m_l[2];
    logic [31:0] m_r[2];

    function automatic int winner(input int k);
        if (req0_valid && req1_valid) return (k == 1) ? 0 : (m_l[k] ? 0 : 1);
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    function automatic logic slot_free(input int k);
        logic owner_rdy;
        owner_rdy = m_o[k] ? rsp1_ready : rsp0_ready;
        return !m_v[k] || owner_rdy;
    endfunction

    task automatic model_step(input int k);
        int w;
        logic fr;
        w  = winner(k);
        fr = slot_free(k);
        if (fr && w >= 0) begin
            m_r[k] = (w == 0) ? ref_alu(req0_alucode, req0_op1, req0_op2)
                              : ref_alu(req1_alucode, req1_op1, req1_op2);
            m_v[k] = 1'b1;
            m_o[k] = w[0];
            m_l[k] = w[0];
        end else if (fr) begin
            m_v[k] = 1'b0;
        end
    endtask

    initial begin
        vecs[0]  = mk(1, ALU_ADD, 34, 55,             0, ALU_ADD, 0, 0,                   1, 1, 1, 0, 1, 0, 32'd89);
        vecs[1]  = mk(0, ALU_ADD, 0, 0,               1, ALU_SUB, 55, 56,                 1, 1, 0, 1, 0, 1, 32'hFFFFFFFF);
        vecs[2]  = mk(1, ALU_ADD, 1, 1,               1, ALU_SRA, 32'hDEADDEAD, 16,       1, 1, 1, 0, 1, 0, 32'd2);
        vecs[3]  = mk(1, ALU_ADD, 1, 1,               1, ALU_SRA, 32'hDEADDEAD, 16,       1, 1, 0, 1, 0, 1, 32'hFFFFDEAD);
        vecs[4]  = mk(1, ALU_ADD, 1, 1,               1, ALU_SRA, 32'hDEADDEAD, 16,       1, 1, 1, 0, 1, 0, 32'd2);
        vecs[5]  = mk(1, ALU_ADD, 1, 1,               1, ALU_SRA, 32'hDEADDEAD, 16,       1, 1, 0, 1, 0, 1, 32'hFFFFDEAD);
        vecs[6]  = mk(1, ALU_SLL, 32'hFEEDFACE, 1036, 0, ALU_ADD, 0, 0,                   0, 1, 1, 0, 1, 0, 32'hDFACE000);
        vecs[7]  = mk(0, ALU_ADD, 0, 0,               1, ALU_AND, 32'hBADCAB1E, 32'hFEEDFACE, 0, 1, 0, 0, 1, 0, 32'hDFACE000);
        vecs[8]  = mk(0, ALU_ADD, 0, 0,               1, ALU_AND, 32'hBADCAB1E, 32'hFEEDFACE, 0, 1, 0, 0, 1, 0, 32'hDFACE000);
        vecs[9]  = mk(0, ALU_ADD, 0, 0,               1, ALU_AND, 32'hBADCAB1E, 32'hFEEDFACE, 0, 1, 0, 0, 1, 0, 32'hDFACE000);
        vecs[10] = mk(0, ALU_ADD, 0, 0,               1, ALU_AND, 32'hBADCAB1E, 32'hFEEDFACE, 1, 1, 0, 1, 0, 1, 32'hBACCAA0E);
        vecs[11] = mk(0, ALU_ADD, 0, 0,               0, ALU_ADD, 0, 0,                   1, 1, 0, 0, 0, 0, 32'hBACCAA0E);

        // Reset state, including ready following free while held in reset
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_rsp0_valid", 32'(v0_rr), 0);
        chk("reset_rsp1_valid", 32'(v1_rr), 0);
        chk("reset_busy", 32'(busy_rr), 0);
        chk("reset_result", res_rr, 0);
        req0_valid = 1'b1;
        #1 chk("reset_req0_ready", 32'(rdy0_rr), 1);
        req1_valid = 1'b1;
        #1 chk("reset_tie_rdy0", 32'(rdy0_rr), 1);
        chk("reset_tie_rdy1", 32'(rdy1_rr), 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Directed vector table on the round-robin instance
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v0, vecs[i].c0, vecs[i].a0, vecs[i].b0,
                  vecs[i].v1, vecs[i].c1, vecs[i].a1, vecs[i].b1, vecs[i].r0, vecs[i].r1);
            #2;
            chk($sformatf("vec%0d_req0_ready", i), 32'(rdy0_rr), 32'(vecs[i].e_rdy0));
            chk($sformatf("vec%0d_req1_ready", i), 32'(rdy1_rr), 32'(vecs[i].e_rdy1));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_rsp0_valid", i), 32'(v0_rr), 32'(vecs[i].e_v0));
            chk($sformatf("vec%0d_rsp1_valid", i), 32'(v1_rr), 32'(vecs[i].e_v1));
            chk($sformatf("vec%0d_busy", i), 32'(busy_rr), 32'(vecs[i].e_v0 | vecs[i].e_v1));
            chk($sformatf("vec%0d_result", i), res_rr, vecs[i].e_res);
        end

        // Fixed priority: port 0 wins every cycle, port 1 starves
        do_reset();
        drive(1, ALU_ADD, 1, 1, 1, ALU_SRA, 32'hDEADDEAD, 16, 1, 1);
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("fixed%0d_req0_ready", i), 32'(rdy0_fx), 1);
            chk($sformatf("fixed%0d_req1_ready", i), 32'(rdy1_fx), 0);
            @(posedge clk);
            #1;
            chk($sformatf("fixed%0d_rsp0_valid", i), 32'(v0_fx), 1);
            chk($sformatf("fixed%0d_result", i), res_fx, 32'd2);
        end

        // Reset asserted while a result is held
        do_reset();
        drive(1, ALU_ADD, 34, 55, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("hold_rsp0_valid", 32'(v0_rr), 1);
        chk("hold_result", res_rr, 32'd89);
        rst_n = 1'b0;
        #1;
        chk("midreset_rsp0_valid", 32'(v0_rr), 0);
        chk("midreset_busy", 32'(busy_rr), 0);
        chk("midreset_result", res_rr, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(1, ALU_ADD, 1, 1, 1, ALU_ADD, 2, 2, 1, 1);
        #1;
        chk("postreset_tie_rdy0", 32'(rdy0_rr), 1);
        chk("postreset_tie_rdy1", 32'(rdy1_rr), 0);
        @(posedge clk);
        #1 chk("postreset_result", res_rr, 32'd2);

        // Randomized traffic against the reference model, both modes at once
        do_reset();
        for (int k = 0; k < 2; k++) begin
            m_v[k] = 1'b0; m_o[k] = 1'b0; m_l[k] = 1'b1; m_r[k] = 32'd0;
        end
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, 5'($urandom_range(0, 9)), $urandom,
                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom_range(0, 3) != 0, 5'($urandom_range(0, 9)), $urandom,
                  ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
            #2;
            begin
                int w0, w1;
                logic f0, f1;
                w0 = winner(0); f0 = slot_free(0);
                w1 = winner(1); f1 = slot_free(1);
                chk("rnd_rr_req0_ready", 32'(rdy0_rr), 32'(f0 && w0 == 0));
                chk("rnd_rr_req1_ready", 32'(rdy1_rr), 32'(f0 && w0 == 1));
                chk("rnd_fx_req0_ready", 32'(rdy0_fx), 32'(f1 && w1 == 0));
                chk("rnd_fx_req1_ready", 32'(rdy1_fx), 32'(f1 && w1 == 1));
            end
            chk("rnd_rr_rsp0_valid", 32'(v0_rr), 32'(m_v[0] && !m_o[0]));
            chk("rnd_rr_rsp1_valid", 32'(v1_rr), 32'(m_v[0] && m_o[0]));
            chk("rnd_fx_rsp0_valid", 32'(v0_fx), 32'(m_v[1] && !m_o[1]));
            chk("rnd_fx_rsp1_valid", 32'(v1_fx), 32'(m_v[1] && m_o[1]));
            chk("rnd_rr_busy", 32'(busy_rr), 32'(m_v[0]));
            chk("rnd_fx_busy", 32'(busy_fx), 32'(m_v[1]));
            if (m_v[0]) chk("rnd_rr_result", res_rr, m_r[0]);
            if (m_v[1]) chk("rnd_fx_result", res_fx, m_r[1]);
            @(posedge clk);
            model_step(0);
            model_step(1);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
